// File: rtl/sram_bus_arbiter_pkg.sv
// Shared state encodings and constants for the SRAM bus arbiter and its watchdog.
package sram_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_D_BUSY = 3'd1,
    ARB_I_BUSY = 3'd2,
    ARB_D_DONE = 3'd3,
    ARB_I_DONE = 3'd4,
    ARB_DRAIN  = 3'd5
  } arb_state_t;

  localparam int ArbTimeoutDefault = 255;

  // Counter is never narrower than 8 bits, but widens for large limits.
  function automatic int arb_cnt_width(input int limit);
    return (limit > 255) ? $clog2(limit + 1) : 8;
  endfunction

  function automatic logic arb_is_waiting(input arb_state_t s);
    return (s == ARB_D_BUSY) || (s == ARB_I_BUSY) || (s == ARB_DRAIN);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus cycle watchdog: counts waiting cycles while started, flags the LIMIT-th one.
module bus_watchdog
  import sram_bus_arbiter_pkg::*;
#(
  parameter int LIMIT = ArbTimeoutDefault,
  parameter int CW    = arb_cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  // Expiry marks the current waiting cycle as the last one allowed.
  assign expired = start && (count == LAST);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the single external SRAM bus between instruction fetch and the MEM stage.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ArbTimeoutDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  arb_state_t state;
  logic       wd_start;
  logic       wd_clear;
  logic       wd_expired;
  logic       busy;

  assign busy     = (state == ARB_D_BUSY) || (state == ARB_I_BUSY);
  assign wd_start = arb_is_waiting(state);
  // Restart the count on any entry into a waiting state, including BUSY -> DRAIN.
  assign wd_clear = !wd_start || (busy && flush_i && !bus_ack_i);

  bus_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (wd_start),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  assign mem_stallreq_o = mem_ce_i && (state != ARB_D_DONE) && !flush_i;
  assign if_stallreq_o  = if_ce_i  && (state != ARB_I_DONE) && !flush_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      bus_err_o   <= 1'b0;
      if_data_o   <= '0;
      mem_data_o  <= '0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (!flush_i) begin
            if (mem_ce_i) begin
              bus_req_o   <= 1'b1;
              bus_we_o    <= mem_we_i;
              bus_addr_o  <= mem_addr_i;
              bus_sel_o   <= mem_sel_i;
              bus_wdata_o <= mem_data_i;
              state       <= ARB_D_BUSY;
            end else if (if_ce_i) begin
              bus_req_o   <= 1'b1;
              bus_we_o    <= 1'b0;
              bus_addr_o  <= if_addr_i;
              bus_sel_o   <= 4'b1111;
              bus_wdata_o <= '0;
              state       <= ARB_I_BUSY;
            end
          end
        end

        ARB_D_BUSY, ARB_I_BUSY: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (flush_i) begin
              state <= ARB_IDLE;
            end else if (state == ARB_D_BUSY) begin
              if (!bus_we_o) mem_data_o <= bus_rdata_i;
              state <= ARB_D_DONE;
            end else begin
              if_data_o <= bus_rdata_i;
              state     <= ARB_I_DONE;
            end
          end else if (wd_expired) begin
            // A dead bus still completes the request so the pipeline can move on.
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            if (flush_i) begin
              state <= ARB_IDLE;
            end else if (state == ARB_D_BUSY) begin
              if (!bus_we_o) mem_data_o <= '0;
              state <= ARB_D_DONE;
            end else begin
              if_data_o <= '0;
              state     <= ARB_I_DONE;
            end
          end else if (flush_i) begin
            state <= ARB_DRAIN;
          end
        end

        ARB_D_DONE, ARB_I_DONE: begin
          if (flush_i || !hold_i) state <= ARB_IDLE;
        end

        ARB_DRAIN: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            state     <= ARB_IDLE;
          end else if (wd_expired) begin
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            state     <= ARB_IDLE;
          end
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios plus randomized transactions.
module tb_sram_bus_arbiter;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_stallreq_o;
  logic        hold_i;
  logic        flush_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  logic [31:0] mem_exp;
  logic [31:0] if_exp;

  sram_bus_arbiter #(
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_ce_i        (if_ce_i),
    .if_addr_i      (if_addr_i),
    .if_data_o      (if_data_o),
    .if_stallreq_o  (if_stallreq_o),
    .mem_ce_i       (mem_ce_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_sel_i      (mem_sel_i),
    .mem_data_i     (mem_data_i),
    .mem_data_o     (mem_data_o),
    .mem_stallreq_o (mem_stallreq_o),
    .hold_i         (hold_i),
    .flush_i        (flush_i),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_sel_o      (bus_sel_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i),
    .bus_err_o      (bus_err_o)
  );

  always #5 clk = ~clk;

  // Count bus transactions as rising edges of the request line.
  always @(posedge clk) begin
    if (bus_req_o && !req_prev) req_rises++;
    req_prev = bus_req_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBusIdleReset();
    checkOutput("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
    checkOutput("rst_bus_we", {31'd0, bus_we_o}, 32'd0);
    checkOutput("rst_bus_addr", bus_addr_o, 32'd0);
    checkOutput("rst_bus_sel", {28'd0, bus_sel_o}, 32'd0);
    checkOutput("rst_bus_wdata", bus_wdata_o, 32'd0);
    checkOutput("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
    checkOutput("rst_if_data", if_data_o, 32'd0);
    checkOutput("rst_mem_data", mem_data_o, 32'd0);
  endtask

  // One full transaction from IDLE: request, wait `delay` cycles for ack
  // (delay >= TB_TIMEOUT means the bus never answers), then DONE with optional hold.
  task automatic applyStimulus(input bit side_mem, input bit we, input logic [31:0] addr,
                               input logic [3:0] sel, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int delay,
                               input int hold_cycles, input bit other_ce);
    bit          timeout;
    int          stall_cnt;
    int          rises_before;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_data;
    logic        own_stall;

    timeout      = (delay >= TB_TIMEOUT);
    exp_we       = side_mem ? we : 1'b0;
    exp_sel      = side_mem ? sel : 4'b1111;
    rises_before = req_rises;

    if (side_mem) begin
      mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wdata;
      if_ce_i = other_ce; if_addr_i = $urandom;
    end else begin
      if_ce_i = 1'b1; if_addr_i = addr;
      mem_ce_i = 1'b0; mem_we_i = 1'($urandom); mem_addr_i = $urandom;
      mem_sel_i = 4'($urandom); mem_data_i = $urandom;
    end
    #1;
    own_stall = side_mem ? mem_stallreq_o : if_stallreq_o;
    checkOutput("stall_idle", {31'd0, own_stall}, 32'd1);
    stall_cnt = 1;
    @(negedge clk);

    for (int k = 0; k < TB_TIMEOUT; k++) begin
      checkOutput("busy_req", {31'd0, bus_req_o}, 32'd1);
      checkOutput("busy_addr", bus_addr_o, addr);
      checkOutput("busy_we", {31'd0, bus_we_o}, {31'd0, exp_we});
      checkOutput("busy_sel", {28'd0, bus_sel_o}, {28'd0, exp_sel});
      if (side_mem && we) checkOutput("busy_wdata", bus_wdata_o, wdata);
      if (other_ce) checkOutput("busy_if_stall", {31'd0, if_stallreq_o}, 32'd1);
      own_stall = side_mem ? mem_stallreq_o : if_stallreq_o;
      if (own_stall) stall_cnt++;
      if (k == delay) begin
        bus_ack_i = 1'b1; bus_rdata_i = rdata;
      end else begin
        bus_rdata_i = $urandom;
      end
      @(negedge clk);
      bus_ack_i = 1'b0;
      if (k == delay) break;
    end

    if (side_mem) begin
      if (!we) mem_exp = timeout ? 32'd0 : rdata;
      exp_data = mem_exp;
    end else begin
      if_exp   = timeout ? 32'd0 : rdata;
      exp_data = if_exp;
    end

    own_stall = side_mem ? mem_stallreq_o : if_stallreq_o;
    checkOutput("done_req", {31'd0, bus_req_o}, 32'd0);
    checkOutput("done_data", side_mem ? mem_data_o : if_data_o, exp_data);
    checkOutput("done_stall", {31'd0, own_stall}, 32'd0);
    checkOutput("done_err", {31'd0, bus_err_o}, {31'd0, timeout});
    checkOutput("stall_cycles", stall_cnt, timeout ? TB_TIMEOUT + 1 : delay + 2);
    checkOutput("bus_txns", req_rises - rises_before, 32'd1);
    if (other_ce) checkOutput("done_if_stall", {31'd0, if_stallreq_o}, 32'd1);

    hold_i = 1'b1;
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      own_stall = side_mem ? mem_stallreq_o : if_stallreq_o;
      checkOutput("hold_req", {31'd0, bus_req_o}, 32'd0);
      checkOutput("hold_data", side_mem ? mem_data_o : if_data_o, exp_data);
      checkOutput("hold_stall", {31'd0, own_stall}, 32'd0);
      checkOutput("hold_err", {31'd0, bus_err_o}, 32'd0);
    end
    hold_i = 1'b0;
    @(negedge clk);
    checkOutput("no_reissue", {31'd0, bus_req_o}, 32'd0);
    checkOutput("bus_txns_after", req_rises - rises_before, 32'd1);
    mem_ce_i = 1'b0;
    if_ce_i  = 1'b0;
  endtask

  initial begin
    bit          r_mem;
    bit          r_we;
    bit          r_other;
    int          r_delay;
    logic [31:0] keep;

    rst = 1'b0; if_ce_i = 1'b0; if_addr_i = '0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0; hold_i = 1'b0; flush_i = 1'b0;
    bus_rdata_i = '0; bus_ack_i = 1'b0;
    mem_exp = '0; if_exp = '0;
    repeat (2) @(negedge clk);
    checkBusIdleReset();
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] single load");
    applyStimulus(1'b1, 1'b0, 32'h8000_0010, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1, 0, 1'b0);

    $display("[TB] store/fetch conflict");
    applyStimulus(1'b1, 1'b1, 32'h8000_0040, 4'b0011, 32'h1234_5678, 32'hAAAA_5555, 1, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0, 32'h0C0F_FEE0, 0, 0, 1'b0);

    $display("[TB] hold in I_DONE");
    applyStimulus(1'b0, 1'b0, 32'h0000_1004, 4'b0000, 32'h0, 32'h1357_9BDF, 2, 4, 1'b0);

    $display("[TB] flush mid-transaction");
    keep = mem_exp;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h8000_0100; mem_sel_i = 4'hF;
    @(negedge clk);
    flush_i = 1'b1; if_ce_i = 1'b1;
    #1;
    checkOutput("flush_mem_stall", {31'd0, mem_stallreq_o}, 32'd0);
    checkOutput("flush_if_stall", {31'd0, if_stallreq_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0; mem_ce_i = 1'b0; if_ce_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("drain_req", {31'd0, bus_req_o}, 32'd1);
      checkOutput("drain_data", mem_data_o, keep);
      if (k == 2) begin
        bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      bus_ack_i = 1'b0;
    end
    checkOutput("drain_end_req", {31'd0, bus_req_o}, 32'd0);
    checkOutput("drain_end_data", mem_data_o, keep);
    checkOutput("drain_end_err", {31'd0, bus_err_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h8000_0104, 4'b1100, 32'h0, 32'h2468_ACE0, 0, 0, 1'b0);

    $display("[TB] flush with ack while busy");
    keep = if_exp;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_2000;
    @(negedge clk);
    flush_i = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hFEED_FACE;
    @(negedge clk);
    flush_i = 1'b0; bus_ack_i = 1'b0; if_ce_i = 1'b0;
    checkOutput("flush_ack_req", {31'd0, bus_req_o}, 32'd0);
    checkOutput("flush_ack_data", if_data_o, keep);

    $display("[TB] flush in IDLE");
    mem_ce_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_idle_req", {31'd0, bus_req_o}, 32'd0);
    mem_ce_i = 1'b0; flush_i = 1'b0;

    $display("[TB] timeout");
    applyStimulus(1'b0, 1'b0, 32'h0000_3000, 4'b0000, 32'h0, 32'h5A5A_5A5A, TB_TIMEOUT, 2, 1'b0);
    $display("[TB] ack on last allowed cycle");
    applyStimulus(1'b0, 1'b0, 32'h0000_3004, 4'b0000, 32'h0, 32'hA5A5_A5A5, TB_TIMEOUT - 1, 1, 1'b0);

    $display("[TB] reset during I_BUSY");
    if_ce_i = 1'b1; if_addr_i = 32'h0000_4000;
    @(negedge clk);
    checkOutput("pre_rst_req", {31'd0, bus_req_o}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkBusIdleReset();
    mem_exp = '0; if_exp = '0;
    rst = 1'b1; if_ce_i = 1'b0;
    @(negedge clk);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 24; n++) begin
      r_mem   = 1'($urandom);
      r_we    = 1'($urandom);
      r_other = r_mem & 1'($urandom);
      r_delay = $urandom_range(0, TB_TIMEOUT);
      applyStimulus(r_mem, r_we, $urandom, 4'($urandom), $urandom, $urandom,
                    r_delay, $urandom_range(0, 2), r_other);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares the single external SRAM/bus port between instruction fetch and the memory-access stage. A registered FSM grants one requester at a time, holds bus signals stable until `bus_ack_i`, and returns read data. It raises per-side stall requests to the pipeline controller and survives exception flushes without corrupting an in-flight bus cycle. It sits between the IF/MEM stages and the top-level bus.

## Interface
- `TIMEOUT`, default 255: cycles without `bus_ack_i` before a transaction is force-terminated.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `if_ce_i` in 1: fetch request; `if_addr_i` in 32: fetch address.
- `if_data_o` out 32: fetched instruction, valid in I_DONE.
- `if_stallreq_o` out 1: fetch side must stall.
- `mem_ce_i` in 1: data request; `mem_we_i` in 1: write.
- `mem_addr_i` in 32, `mem_sel_i` in 4, `mem_data_i` in 32: address, byte lanes, write data.
- `mem_data_o` out 32: load data, valid in D_DONE; `mem_stallreq_o` out 1: MEM side must stall.
- `hold_i` in 1: pipeline frozen by another stall source.
- `flush_i` in 1: exception flush.
- `bus_req_o` out 1, `bus_we_o` out 1, `bus_addr_o` out 32, `bus_sel_o` out 4, `bus_wdata_o` out 32: registered bus request.
- `bus_rdata_i` in 32, `bus_ack_i` in 1: bus response, ack is a 1-cycle pulse.
- `bus_err_o` out 1: 1-cycle pulse on timeout.

## Operation
- States: IDLE, D_BUSY, I_BUSY, D_DONE, I_DONE, DRAIN.
- IDLE:
  - `mem_ce_i` → latch addr/we/sel/wdata, go D_BUSY.
  - Else `if_ce_i` → latch addr, we=0, sel=4'b1111, go I_BUSY.
  - Data always wins a same-cycle conflict.
- x_BUSY:
  - `bus_req_o`=1 with latched fields held constant.
  - On `bus_ack_i`: capture `bus_rdata_i` into `mem_data_o`/`if_data_o`, go x_DONE.
- x_DONE:
  - Stall deasserted for the owner; pipeline advances on this edge.
  - `hold_i`=0 → IDLE, with no re-issue even though `ce` is still high this cycle.
  - `hold_i`=1 → stay, data held.
- Stall requests:
  - `mem_stallreq_o` = `mem_ce_i` & state≠D_DONE.
  - `if_stallreq_o` = `if_ce_i` & state≠I_DONE.
  - Both forced to 0 while `flush_i`=1.
- `flush_i`:
  - In IDLE/DONE → IDLE, and no request is accepted that cycle.
  - In BUSY → DRAIN.
- DRAIN: `bus_req_o` stays 1 until `bus_ack_i`, data is discarded, then IDLE.
- Timeout:
  - An 8+ bit counter clears on BUSY/DRAIN entry and increments each waiting cycle.
  - When it reaches `TIMEOUT` with no ack: drop `bus_req_o`, pulse `bus_err_o`, return 32'h0.
  - Exit is BUSY → DONE, or DRAIN → IDLE.
- Writes return no data; `mem_data_o` keeps its previous value.

## Timing
- Reset values: state IDLE; all `bus_*` outputs, `bus_err_o`, `if_data_o` and `mem_data_o` are 0. Stall outputs follow their combinational rule from state IDLE.
- Request seen in IDLE at cycle N:
  - `bus_req_o`=1 at N+1.
  - Earliest ack at N+1.
  - DONE at N+2.
  - Minimum occupancy is 3 cycles.
- `bus_req_o` only falls the cycle after ack or timeout. Ack while `bus_req_o`=0 is ignored.
- Ack and timeout in the same cycle: ack wins and no error is raised.
- Flush and ack in the same cycle while BUSY: go IDLE directly, data discarded.
- Reset mid-transaction: abandon immediately and drop `bus_req_o` next edge. The bus is responsible for tolerating this.

## Structure
- Add state encodings (3-bit `ARB_IDLE`…`ARB_DRAIN`) and `ArbTimeoutDefault` to `defines.v` alongside the existing pipeline constants.
- One natural sub-module: `bus_watchdog` (counter plus compare, `start`/`clear`/`expired`). Everything else is a single FSM in `sram_bus_arbiter`.

## Test plan
- Single load:
  - Stimulus: `mem_ce_i`=1, addr 0x80000010, ack 2 cycles after req, rdata 0xDEADBEEF.
  - Response: `mem_stallreq_o`=1 for 3 cycles, then D_DONE with `mem_data_o`=0xDEADBEEF and exactly one bus transaction.
- Conflict:
  - Stimulus: `if_ce_i` and `mem_ce_i` both 1, `mem_we_i`=1, data 0x12345678, sel 4'b0011.
  - Response: store goes first with `bus_sel_o`=0011; `if_stallreq_o` stays 1 until I_DONE; fetch is issued after D_DONE.
- Hold:
  - Stimulus: `hold_i`=1 for 4 cycles in I_DONE.
  - Response: no second bus request; `if_data_o` stable.
- Flush mid-transaction:
  - Stimulus: `flush_i` in D_BUSY, ack 3 cycles later.
  - Response: `bus_req_o` held until ack, `mem_data_o` unchanged, IDLE next cycle.
- Timeout:
  - Stimulus: `TIMEOUT`=4, never ack.
  - Response: `bus_req_o` drops after 4 waiting cycles, `bus_err_o` pulses once, `if_data_o`=0.
- Reset:
  - Stimulus: `rst`=0 during I_BUSY.
  - Response: next edge state IDLE and `bus_req_o`=0; all data outputs 0.
